range_burst_sequencer: RTL and testbench

- Upstream feeder for the range-finder core.
- Accepts a byte stream of samples on a valid/ready interface, with a last flag marking the end of each burst, and buffers it in a small FIFO.
- Replays each complete burst to the range finder as one gap-free go … finish sequence, one sample per clock.
- The range finder samples every cycle and cannot be stalled, so a burst is released only once it is fully buffered.

---
 rtl/range_burst_sequencer.sv | 153 +++++++++++++++
 tb/tb_range_burst_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/range_burst_sequencer.sv
// Burst-buffering feeder for the range finder.
// Buffers whole bursts, then replays each one gap-free, one sample per clock.
module range_burst_sequencer #(
   parameter int DEPTH = 16,
   parameter int GAP   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] rf_data,
   output logic       rf_go,
   output logic       rf_finish,
   output logic       busy,
   output logic       ovf_err,
   output logic [7:0] burst_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP + 1) + 1;
   localparam logic [GW-1:0] GLAST = GW'(GAP - 1);
   localparam logic [AW:0]   P_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [GW-1:0] G_ONE = {{(GW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_STREAM, S_FIN1, S_GAP
   } st_t;

   typedef enum logic {
      I_ACCEPT, I_DROP
   } in_t;

   logic [8:0]    r_mem [DEPTH];
   logic [AW:0]   r_wp;
   logic [AW:0]   r_rp;
   logic [AW:0]   r_lcnt;
   logic          r_en;
   in_t           r_in;
   st_t           r_st;
   logic [GW-1:0] r_gcnt;
   logic [7:0]    r_data;
   logic          r_go;
   logic          r_fin;
   logic          r_ovf;
   logic [7:0]    r_bcnt;

   logic       w_full;
   logic [8:0] w_head;
   logic       w_rd;
   logic       w_wr;
   logic       w_flush;
   logic       w_inc;
   logic       w_dec;

   assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_head  = r_mem[r_rp[AW-1:0]];
   assign w_rd    = (r_st == S_START) || (r_st == S_STREAM);
   assign s_ready = r_en & ((r_in == I_DROP) | ~w_full);
   assign w_wr    = s_valid & s_ready & (r_in == I_ACCEPT);
   // Only a burst with no complete predecessor queued can be flushed.
   assign w_flush = r_en & (r_in == I_ACCEPT) & w_full &
                    (r_lcnt == '0) & s_valid;
   assign w_inc   = w_wr & s_last;
   assign w_dec   = w_rd & w_head[8];

   assign rf_data   = r_data;
   assign rf_go     = r_go;
   assign rf_finish = r_fin;
   assign busy      = (r_st != S_IDLE);
   assign ovf_err   = r_ovf;
   assign burst_cnt = r_bcnt;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= {s_last, s_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_lcnt <= '0;
         r_en   <= 1'b0;
         r_in   <= I_ACCEPT;
         r_ovf  <= 1'b0;
      end else begin
         r_en  <= 1'b1;
         r_ovf <= w_flush;
         if (w_flush) begin
            r_wp <= '0;
            r_rp <= '0;
         end else begin
            if (w_wr) r_wp <= r_wp + P_ONE;
            if (w_rd) r_rp <= r_rp + P_ONE;
         end
         case ({w_inc, w_dec})
            2'b10:   r_lcnt <= r_lcnt + P_ONE;
            2'b01:   r_lcnt <= r_lcnt - P_ONE;
            default: r_lcnt <= r_lcnt;
         endcase
         case (r_in)
            I_ACCEPT: if (w_flush) r_in <= I_DROP;
            I_DROP:   if (s_valid && s_last) r_in <= I_ACCEPT;
            default:  r_in <= I_ACCEPT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st   <= S_IDLE;
         r_gcnt <= '0;
         r_data <= 8'h00;
         r_go   <= 1'b0;
         r_fin  <= 1'b0;
         r_bcnt <= 8'h00;
      end else begin
         r_go  <= 1'b0;
         r_fin <= 1'b0;
         case (r_st)
            S_IDLE: if (r_lcnt != '0) r_st <= S_START;
            S_START: begin
               r_data <= w_head[7:0];
               r_go   <= 1'b1;
               r_st   <= w_head[8] ? S_FIN1 : S_STREAM;
            end
            S_STREAM: begin
               r_data <= w_head[7:0];
               if (w_head[8]) begin
                  r_fin  <= 1'b1;
                  r_bcnt <= r_bcnt + 8'd1;
                  r_gcnt <= '0;
                  r_st   <= S_GAP;
               end
            end
            S_FIN1: begin
               r_fin  <= 1'b1;
               r_bcnt <= r_bcnt + 8'd1;
               r_gcnt <= '0;
               r_st   <= S_GAP;
            end
            S_GAP: begin
               if (r_gcnt == GLAST) r_st <= S_IDLE;
               else r_gcnt <= r_gcnt + G_ONE;
            end
            default: r_st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_range_burst_sequencer.sv
// Scoreboard bench for range_burst_sequencer.
// Bursts are queued as driven and matched against the replay stream.
module tb_range_burst_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [7:0] rf_data;
   logic       rf_go;
   logic       rf_finish;
   logic       busy;
   logic       ovf_err;
   logic [7:0] burst_cnt;

   range_burst_sequencer #(.DEPTH(16), .GAP(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .rf_data   (rf_data),
      .rf_go     (rf_go),
      .rf_finish (rf_finish),
      .busy      (busy),
      .ovf_err   (ovf_err),
      .burst_cnt (burst_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       l;
   } item_t;

   item_t      q[$];
   item_t      m_it;
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         fin_cyc = -100;
   int         n_ovf = 0;
   bit         in_b = 0;
   bit         pend = 0;
   logic [7:0] last_d = 8'h00;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         in_b = 0;
         pend = 0;
      end else begin
         if (ovf_err) n_ovf++;
         if (pend) begin
            chk("fin1", {rf_go, rf_finish, rf_data}, {1'b0, 1'b1, last_d});
            pend = 0;
            fin_cyc = cyc;
         end else if (rf_go || in_b) begin
            if (q.size() == 0) begin
               chk("unexp_beat", 1, 0);
               in_b = 0;
            end else begin
               m_it = q.pop_front();
               if (rf_go) chk("gap", (cyc - fin_cyc - 1) >= 2, 1);
               chk("go", rf_go, m_it.f);
               chk("data", rf_data, m_it.d);
               chk("fin", rf_finish, m_it.l & ~m_it.f);
               in_b = ~m_it.l;
               pend = m_it.f & m_it.l;
               last_d = m_it.d;
               if (m_it.l && !m_it.f) fin_cyc = cyc;
            end
         end else if (rf_finish) begin
            chk("spur_fin", 1, 0);
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      s_data = d;
      s_last = l;
      s_valid = 1'b1;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("rdy_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic burst(input int n, input logic [7:0] base,
                        input logic [7:0] step, input logic lastf,
                        input bit push);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = base + 8'(i) * step;
         if (push) q.push_back({d, i == 0, i == n - 1});
         send(d, lastf && (i == n - 1));
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || busy || pend) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n < 1000, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("rst_out", {s_ready, rf_go, rf_finish, busy, ovf_err, rf_data,
                      burst_cnt}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", s_ready, 1);

      burst(3, 8'h10, 8'h10, 1'b1, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      chk("bcnt_t1", burst_cnt, 1);
      chk("busy_t1", busy, 0);

      burst(1, 8'hA5, 8'h00, 1'b1, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      chk("bcnt_t2", burst_cnt, 2);

      burst(4, 8'h50, 8'h01, 1'b1, 1'b1);
      burst(3, 8'h60, 8'h01, 1'b1, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      chk("bcnt_t3", burst_cnt, 4);

      burst(16, 8'h80, 8'h01, 1'b0, 1'b0);
      send(8'h90, 1'b0);
      send(8'h91, 1'b0);
      send(8'h92, 1'b1);
      burst(2, 8'h01, 8'h01, 1'b1, 1'b1);
      s_valid = 1'b0;
      wait_idle();
      chk("ovf_t4", n_ovf, 1);
      chk("bcnt_t4", burst_cnt, 5);

      burst(16, 8'hC0, 8'h01, 1'b1, 1'b1);
      s_valid = 1'b0;
      chk("full_rdy", s_ready, 0);
      wait_idle();
      chk("bcnt_t5", burst_cnt, 6);
      chk("ovf_t5", n_ovf, 1);

      burst(10, 8'h20, 8'h01, 1'b1, 1'b1);
      s_valid = 1'b0;
      n = 0;
      while (!rf_go && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("go_timeout", n < 200, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid", {s_ready, rf_go, rf_finish, busy, ovf_err, rf_data,
                         burst_cnt}, 0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("bcnt_t6", burst_cnt, 0);
      chk("busy_t6", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
